// File: rtl/share_queue.sv
// Share qualifier and FIFO: tests each result hash against a leading-zero difficulty,
// buffers qualifying {nonce, hash} pairs and presents the head as a framed UART message.
module share_queue #(
    parameter int DEPTH_LOG = 2,
    parameter int CNT_W     = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [255:0]         hash,
    input  logic [31:0]          nonce,
    input  logic                 hash_valid,
    input  logic [7:0]           difficulty,
    output logic [511:0]         tx_data,
    output logic                 tx_req,
    input  logic                 tx_ack,
    output logic [DEPTH_LOG:0]   count,
    output logic [CNT_W-1:0]     drop_count
);

    typedef struct packed {
        logic [31:0]  nonce;
        logic [255:0] hash;
    } share_t;

    localparam int                 DEPTH = 1 << DEPTH_LOG;
    localparam logic [DEPTH_LOG:0] FULL  = (DEPTH_LOG+1)'(DEPTH);

    logic [255:0]         mask;
    logic                 hit;
    logic                 stg_hit;
    share_t               stg;
    share_t               mem [DEPTH];
    share_t               head;
    logic [DEPTH_LOG-1:0] wr_ptr, rd_ptr;
    logic                 full, push, pop, drop;

    // Top `difficulty` bits of the hash must be zero; difficulty 0 gives an empty mask.
    assign mask = ~({256{1'b1}} >> difficulty);
    assign hit  = hash_valid & ((hash & mask) == '0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stg_hit <= 1'b0;
            stg     <= '0;
        end else begin
            stg_hit <= hit;
            stg     <= '{nonce: nonce, hash: hash};
        end
    end

    assign tx_req = (count != '0);
    assign full   = (count == FULL);
    assign pop    = tx_req & tx_ack;
    // A full queue still accepts a share when the head leaves on the same edge.
    assign push   = stg_hit & (~full | pop);
    assign drop   = stg_hit & full & ~pop;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            drop_count <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (push) begin
                mem[wr_ptr] <= stg;
                wr_ptr      <= wr_ptr + (DEPTH_LOG)'(1);
            end
            if (pop) rd_ptr <= rd_ptr + (DEPTH_LOG)'(1);
            case ({push, pop})
                2'b10:   count <= count + (DEPTH_LOG+1)'(1);
                2'b01:   count <= count - (DEPTH_LOG+1)'(1);
                default: count <= count;
            endcase
            if (drop && drop_count != '1) drop_count <= drop_count + CNT_W'(1);
        end
    end

    assign head    = mem[rd_ptr];
    assign tx_data = {64'hdead432987beefaa, 144'h0, 8'haa, head.nonce, 8'haa, head.hash};

endmodule
